// File: rtl/tick_counter_if.sv
// Control and status bundle between the ticks register block (master)
// and the tick counter (slave).
interface tick_counter_if #(
  parameter int PRESCALE_WIDTH = 16
);
  logic                      enable_ticks;
  logic                      reset_ticks;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      snap_hold;
  logic [63:0]               data_tick;
  logic                      tick_pulse;
  logic                      overflow;
  logic                      running;

  modport master (
    output enable_ticks, reset_ticks, prescale, snap_hold,
    input  data_tick, tick_pulse, overflow, running
  );

  modport slave (
    input  enable_ticks, reset_ticks, prescale, snap_hold,
    output data_tick, tick_pulse, overflow, running
  );
endinterface

// File: rtl/tick_counter.sv
// Free-running 64-bit tick counter with programmable prescaler, wrap or
// saturate on overflow, rising-edge clear and a snapshot hold on data_tick.
module tick_counter #(
  parameter int PRESCALE_WIDTH = 16,
  parameter int SATURATE       = 0
) (
  input  logic            clk,
  input  logic            reset,
  tick_counter_if.slave   bus
);

  logic [63:0]               count, count_nxt;
  logic [PRESCALE_WIDTH-1:0] pre_cnt, pre_nxt;
  logic [PRESCALE_WIDTH-1:0] eff;
  logic [63:0]               data_q, data_nxt;
  logic                      pulse_q, pulse_nxt;
  logic                      ovf_q, ovf_nxt;
  logic                      run_q;
  logic                      rst_d;
  logic                      clr;

  // Only the rising edge of reset_ticks clears; a held level clears once.
  assign clr = bus.reset_ticks & ~rst_d;
  assign eff = (bus.prescale == '0) ? PRESCALE_WIDTH'(1) : bus.prescale;

  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    count_nxt = count;
    pre_nxt   = pre_cnt;
    pulse_nxt = 1'b0;
    ovf_nxt   = ovf_q;
    data_nxt  = bus.snap_hold ? data_q : count;

    if (clr) begin
      count_nxt = '0;
      pre_nxt   = '0;
      ovf_nxt   = 1'b0;
      data_nxt  = '0;
    end else if (bus.enable_ticks) begin
      // >= rather than == so a prescale lowered below pre_cnt fires next cycle.
      if (pre_cnt >= eff - PRESCALE_WIDTH'(1)) begin
        pre_nxt = '0;
        if (count != '1) begin
          count_nxt = count + 64'd1;
          pulse_nxt = 1'b1;
        end else if (SATURATE == 0) begin
          count_nxt = '0;
          ovf_nxt   = 1'b1;
          pulse_nxt = 1'b1;
        end else begin
          ovf_nxt   = 1'b1;
        end
      end else begin
        pre_nxt = pre_cnt + PRESCALE_WIDTH'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so all of them see
  // the pre-edge values of each other.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      pre_cnt <= '0;
      data_q  <= '0;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
      run_q   <= 1'b0;
      rst_d   <= 1'b0;
    end else begin
      count   <= count_nxt;
      pre_cnt <= pre_nxt;
      data_q  <= data_nxt;
      pulse_q <= pulse_nxt;
      ovf_q   <= ovf_nxt;
      run_q   <= bus.enable_ticks;
      rst_d   <= bus.reset_ticks;
    end
  end

  assign bus.data_tick  = data_q;
  assign bus.tick_pulse = pulse_q;
  assign bus.overflow   = ovf_q;
  assign bus.running    = run_q;

endmodule

// File: doc/tick_counter.md
Name: tick_counter

Overview:
Free-running 64-bit tick counter that produces data_tick for the ticks register block. It consumes that block's enable_ticks and reset_ticks controls. A programmable prescaler divides clk into count events. Overflow can wrap or saturate, and a snapshot hold lets software read the H and L words from one coherent 64-bit value.

Parameters:
PRESCALE_WIDTH, 16, width of the prescale input and of the internal prescaler counter.
SATURATE, 0, 0 = counter wraps at 2^64-1, 1 = counter sticks at all-ones.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset; 0 forces all state to reset values immediately.
enable_ticks  input  1  level; 1 = count, 0 = hold.
reset_ticks  input  1  level from the register block; only its rising edge clears the counter.
prescale  input  PRESCALE_WIDTH  clk cycles per count event; 0 is treated as 1.
snap_hold  input  1  1 = freeze data_tick; count keeps running.
data_tick  output  64  registered copy of the count, for the register block.
tick_pulse  output  1  one-cycle pulse on each count increment.
overflow  output  1  sticky flag; set when the count wraps or saturates.
running  output  1  registered copy of enable_ticks.

Behaviour:
- Reset (reset=0, asynchronous): count, pre_cnt, data_tick = 0. tick_pulse, overflow, running, rst_d = 0. Effect is immediate, including mid-count.
- Clear detect:
  - rst_d <= reset_ticks every cycle; clr = reset_ticks & ~rst_d.
  - A held-high reset_ticks clears exactly once.
- Clear action (clr=1):
  - count, pre_cnt, overflow <= 0; tick_pulse <= 0.
  - data_tick <= 0 regardless of snap_hold.
  - Clear has priority over increment in the same cycle.
- Effective divisor: eff = (prescale==0) ? 1 : prescale.
- Prescaler, when enable_ticks=1 and no clr:
  - If pre_cnt >= eff-1: pre_cnt <= 0 and a count event occurs. Otherwise pre_cnt <= pre_cnt+1.
  - Using >= handles prescale lowered below the current pre_cnt: the event fires on the next cycle.
- enable_ticks=0: pre_cnt and count hold; tick_pulse <= 0.
- Count event:
  - Below all-ones: count <= count+1, tick_pulse <= 1.
  - At all-ones, SATURATE=0: count <= 0, overflow <= 1, tick_pulse <= 1.
  - At all-ones, SATURATE=1: count holds, overflow <= 1, tick_pulse <= 0.
- No count event: tick_pulse <= 0.
- overflow is sticky; only reset or clr clears it.
- data_tick:
  - snap_hold=0: data_tick <= count, one cycle behind count.
  - snap_hold=1: data_tick holds.
  - Releasing snap_hold resumes tracking on the next edge.
- running <= enable_ticks; one cycle latency.
- Latency, prescale=1: enable_ticks high at edge N gives count=1 after edge N, tick_pulse=1 after edge N, data_tick=1 after edge N+1.
- All arithmetic is unsigned. count is 64 bits. pre_cnt is PRESCALE_WIDTH bits and never exceeds eff-1 after a terminal cycle.

Test Plan:
- Basic count: prescale=1, enable for 10 cycles, then disable -> data_tick settles at 10; tick_pulse high for exactly 10 cycles; running follows enable one cycle late.
- Prescale: prescale=4, enable for 20 cycles -> count=5; tick_pulse every 4th cycle. prescale=0 -> same as prescale=1.
- Clear edge:
  - Hold reset_ticks high for 5 cycles mid-count -> count=0 once, then resumes counting while reset_ticks stays high.
  - overflow cleared.
  - clr and a count event in the same cycle -> count=0.
- Wrap/saturate:
  - SATURATE=0, count preloaded near all-ones (drive via hierarchical force) -> 0xFFFF_FFFF_FFFF_FFFF then 0, overflow=1.
  - SATURATE=1 -> stays all-ones, tick_pulse=0, overflow=1.
- Snapshot: count crossing 0x0000_0000_FFFF_FFFF, assert snap_hold -> data_tick frozen while count advances; release -> data_tick = count one cycle later; clr while held -> data_tick=0.
- Async reset: drop reset mid-count between clock edges -> all outputs 0 before the next edge; counting restarts after release.
